// File: rtl/bcd_countdown_hms_if.sv
// Control/preset/status bundle for the BCD HH:MM:SS countdown timer.
// Master drives strobes and preset; slave returns remaining time and status.
interface bcd_countdown_hms_if;
  logic       i_tick;
  logic       i_load;
  logic       i_start;
  logic       i_stop;
  logic [7:0] i_hh;
  logic [7:0] i_mm;
  logic [7:0] i_ss;
  logic [7:0] o_hh;
  logic [7:0] o_mm;
  logic [7:0] o_ss;
  logic       o_running;
  logic       o_done;

  modport master (
    output i_tick, i_load, i_start, i_stop,
    output i_hh, i_mm, i_ss,
    input  o_hh, o_mm, o_ss, o_running, o_done
  );

  modport slave (
    input  i_tick, i_load, i_start, i_stop,
    input  i_hh, i_mm, i_ss,
    output o_hh, o_mm, o_ss, o_running, o_done
  );
endinterface

// File: rtl/bcd_countdown_hms.sv
// BCD HH:MM:SS countdown timer with preset shadow and expiry pulse.
// Optional: BCD_COUNTDOWN_AUTO_RELOAD_EN reloads from the shadow on expiry.
module bcd_countdown_hms #(
  parameter logic [7:0] HH_MAX = 8'h99
) (
  input logic i_clk,
  input logic i_rst,
  bcd_countdown_hms_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] shadow_q, shadow_d;
  logic        running_q, running_d;
  logic        done_q, done_d;
  logic [23:0] preset;
  logic [23:0] dec;

  function automatic logic [3:0] nib_clamp(
    input logic [3:0] n,
    input logic [3:0] mx
  );
    return (n > mx) ? mx : n;
  endfunction

  function automatic logic [7:0] ms_clamp(input logic [7:0] v);
    return {nib_clamp(v[7:4], 4'd5), nib_clamp(v[3:0], 4'd9)};
  endfunction

  function automatic logic [7:0] hh_clamp(input logic [7:0] v);
    logic [7:0] t;
    t = {nib_clamp(v[7:4], 4'd9), nib_clamp(v[3:0], 4'd9)};
    return (t > HH_MAX) ? HH_MAX : t;
  endfunction

  // Wraps 00 to 59; caller decides whether a borrow moves on.
  function automatic logic [7:0] ms_dec(input logic [7:0] v);
    if (v[3:0] != 4'd0) return {v[7:4], v[3:0] - 4'd1};
    else if (v[7:4] != 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else return 8'h59;
  endfunction

  function automatic logic [7:0] hh_dec(input logic [7:0] v);
    if (v[3:0] != 4'd0) return {v[7:4], v[3:0] - 4'd1};
    else return {v[7:4] - 4'd1, 4'd9};
  endfunction

  always_comb begin
    preset = {hh_clamp(bus.i_hh), ms_clamp(bus.i_mm), ms_clamp(bus.i_ss)};
    dec[7:0]   = ms_dec(cnt_q[7:0]);
    dec[15:8]  = cnt_q[15:8];
    dec[23:16] = cnt_q[23:16];
    if (cnt_q[7:0] == 8'h00) begin
      dec[15:8] = ms_dec(cnt_q[15:8]);
      if (cnt_q[15:8] == 8'h00) dec[23:16] = hh_dec(cnt_q[23:16]);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    if (bus.i_load) begin
      cnt_d    = preset;
      shadow_d = preset;
      state_d  = IDLE;
    end else if (bus.i_stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (bus.i_start) begin
      if ((state_q == IDLE || state_q == PAUSE) && cnt_q != '0)
        state_d = RUN;
    end else if (bus.i_tick && state_q == RUN && cnt_q != '0) begin
      cnt_d = dec;
      if (dec == '0) begin
        done_d  = 1'b1;
        state_d = EXPIRED;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
        if (shadow_q != '0) begin
          cnt_d   = shadow_q;
          state_d = RUN;
        end
`endif
      end
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bus.o_hh      = cnt_q[23:16];
  assign bus.o_mm      = cnt_q[15:8];
  assign bus.o_ss      = cnt_q[7:0];
  assign bus.o_running = running_q;
  assign bus.o_done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_hms.sv
// Bench for bcd_countdown_hms: directed plan steps plus random traffic
// against a seconds-count reference model.
module tb_bcd_countdown_hms;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  bcd_countdown_hms_if bus ();

  bcd_countdown_hms dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: 0 idle, 1 run, 2 pause, 3 expired; time held as plain seconds.
  int m_st;
  int m_secs;
  int m_shadow;
  bit m_done;

  function automatic int digit_clamp(input int d, input int mx);
    return (d > mx) ? mx : d;
  endfunction

  function automatic int preset_secs(
    input logic [7:0] hh,
    input logic [7:0] mm,
    input logic [7:0] ss
  );
    int h, m, s;
    h = 10 * digit_clamp(int'(hh[7:4]), 9) + digit_clamp(int'(hh[3:0]), 9);
    m = 10 * digit_clamp(int'(mm[7:4]), 5) + digit_clamp(int'(mm[3:0]), 9);
    s = 10 * digit_clamp(int'(ss[7:4]), 5) + digit_clamp(int'(ss[3:0]), 9);
    if (h > 99) h = 99;
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  task automatic model_step(
    input bit ld, input logic [7:0] hh, input logic [7:0] mm,
    input logic [7:0] ss, input bit st, input bit sp, input bit tk
  );
    m_done = 1'b0;
    if (ld) begin
      m_shadow = preset_secs(hh, mm, ss);
      m_secs   = m_shadow;
      m_st     = 0;
    end else if (sp) begin
      if (m_st == 1) m_st = 2;
    end else if (st) begin
      if ((m_st == 0 || m_st == 2) && m_secs != 0) m_st = 1;
    end else if (tk && m_st == 1 && m_secs > 0) begin
      m_secs = m_secs - 1;
      if (m_secs == 0) begin
        m_done = 1'b1;
        m_st   = 3;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
        if (m_shadow != 0) begin
          m_secs = m_shadow;
          m_st   = 1;
        end
`endif
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".hh"}, bus.o_hh, to_bcd(m_secs / 3600));
    chk({tag, ".mm"}, bus.o_mm, to_bcd((m_secs / 60) % 60));
    chk({tag, ".ss"}, bus.o_ss, to_bcd(m_secs % 60));
    chk({tag, ".run"}, {7'd0, bus.o_running}, {7'd0, m_st == 1});
    chk({tag, ".done"}, {7'd0, bus.o_done}, {7'd0, m_done});
  endtask

  task automatic step(
    input string tag, input bit ld, input logic [7:0] hh,
    input logic [7:0] mm, input logic [7:0] ss,
    input bit st, input bit sp, input bit tk
  );
    @(negedge clk);
    bus.i_load  = ld;
    bus.i_hh    = hh;
    bus.i_mm    = mm;
    bus.i_ss    = ss;
    bus.i_start = st;
    bus.i_stop  = sp;
    bus.i_tick  = tk;
    @(posedge clk);
    model_step(ld, hh, mm, ss, st, sp, tk);
    #1;
    check_all(tag);
  endtask

  task automatic load(input string tag, input logic [7:0] hh,
                      input logic [7:0] mm, input logic [7:0] ss);
    step(tag, 1, hh, mm, ss, 0, 0, 0);
  endtask

  task automatic start(input string tag);
    step(tag, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0);
  endtask

  task automatic tick(input string tag);
    step(tag, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1);
  endtask

  task automatic model_reset();
    m_st = 0; m_secs = 0; m_shadow = 0; m_done = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    model_reset();
    rst = 1'b0;
    bus.i_load = 0; bus.i_start = 0; bus.i_stop = 0; bus.i_tick = 0;
    bus.i_hh = 8'h00; bus.i_mm = 8'h00; bus.i_ss = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    load("ld3", 8'h00, 8'h00, 8'h03);
    start("st3");
    tick("t3a");
    tick("t3b");
    tick("t3c");
    tick("t3d");
    tick("t3e");

    load("ld10h", 8'h10, 8'h00, 8'h00);
    start("st10h");
    tick("b10h");
    load("ld1h", 8'h01, 8'h00, 8'h00);
    start("st1h");
    tick("b1h");

    load("clamp", 8'hA7, 8'h7C, 8'h65);

    load("ldp", 8'h00, 8'h00, 8'h05);
    step("st_tk", 0, 8'h00, 8'h00, 8'h00, 1, 0, 1);
    tick("p1");
    step("sp_tk", 0, 8'h00, 8'h00, 8'h00, 0, 1, 1);
    step("ss_pause", 0, 8'h00, 8'h00, 8'h00, 1, 1, 0);
    start("resume");
    load("ld_idle", 8'h00, 8'h00, 8'h09);
    step("ss_idle", 0, 8'h00, 8'h00, 8'h00, 1, 1, 0);
    load("ld5", 8'h00, 8'h00, 8'h05);
    start("st5");
    load("ld_run", 8'h00, 8'h01, 8'h00);

    load("ld10", 8'h00, 8'h00, 8'h10);
    start("st10");
    repeat (4) tick("r10");
    step("stop10", 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    repeat (5) tick("paused");
    start("res10");
    tick("res10t");

    load("ld1", 8'h00, 8'h00, 8'h01);
    start("st1");
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all("arst_now");
    @(posedge clk);
    #1;
    check_all("arst_hold");
    @(negedge clk);
    rst = 1'b1;

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    load("ar_ld", 8'h00, 8'h00, 8'h02);
    start("ar_st");
    tick("ar_t1");
    tick("ar_t2");
    tick("ar_t3");
`endif

    for (int i = 0; i < 400; i++) begin
      logic [7:0] hh, mm, ss;
      bit ld, st, sp, tk;
      ld = ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 11) == 0);
      tk = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) begin
        hh = 8'($urandom); mm = 8'($urandom); ss = 8'($urandom);
      end else begin
        hh = 8'h00;
        mm = 8'($urandom_range(0, 1));
        ss = 8'($urandom_range(0, 9));
      end
      step("rand", ld, hh, mm, ss, st, sp, tk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
